// File: rtl/stream_join_pipe_fork.sv
// Joins two valid/ready input streams into one word, optionally registers it
// (STREAM_JOIN_PIPE_FORK_PIPE_EN), then forks it to two independently-stalling outputs.
module stream_join_pipe_fork #(
    parameter int    WIDTH0 = 8,
    parameter int    WIDTH1 = 8,
    parameter string BURST  = "yes"
) (
    input  logic              iCLK,
    input  logic              iRST,

    input  logic              iValid_AS0,
    output logic              oReady_AS0,
    input  logic [WIDTH0-1:0] iData_AS0,

    input  logic              iValid_AS1,
    output logic              oReady_AS1,
    input  logic [WIDTH1-1:0] iData_AS1,

    output logic              oValid_BM0,
    input  logic              iReady_BM0,
    output logic [WIDTH0-1:0] oData_BM0,

    output logic              oValid_BM1,
    input  logic              iReady_BM1,
    output logic [WIDTH1-1:0] oData_BM1
);

    // Every port: a word moves in a cycle where valid and ready are both 1.
    // Valid never depends on ready; ready may depend on valid and downstream ready.

    localparam int  WW       = WIDTH0 + WIDTH1;
    localparam bit  burst_en = (BURST == "yes");

    logic          join_valid;
    logic          join_ready;
    logic [WW-1:0] join_data;

    logic          fork_valid;
    logic          fork_ready;
    logic [WW-1:0] fork_data;

    // Join: both inputs are consumed together or not at all.
    assign join_valid = iValid_AS0 & iValid_AS1;
    assign join_data  = {iData_AS1, iData_AS0};
    assign oReady_AS0 = join_ready & iValid_AS1;
    assign oReady_AS1 = join_ready & iValid_AS0;

`ifdef STREAM_JOIN_PIPE_FORK_PIPE_EN
    logic          pipe_valid;
    logic [WW-1:0] pipe_data;
    logic          pipe_load;

    assign join_ready = !pipe_valid | fork_ready;
    assign pipe_load  = join_valid & join_ready;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
        end else if (pipe_load) begin
            pipe_valid <= 1'b1;
            pipe_data  <= join_data;
        end else if (fork_ready) begin
            pipe_valid <= 1'b0;
        end
    end

    assign fork_valid = pipe_valid;
    assign fork_data  = pipe_data;
`else
    assign join_ready = fork_ready;
    assign fork_valid = join_valid;
    assign fork_data  = join_data;
`endif

    logic          flag0;
    logic          flag1;
    logic [WW-1:0] fork_word;
    logic          fork_accept;

    // A flag that is being transferred this cycle counts as free in burst mode.
    generate
        if (burst_en) begin : g_burst
            assign fork_ready = (!flag0 | iReady_BM0) & (!flag1 | iReady_BM1);
        end else begin : g_bubble
            assign fork_ready = !flag0 & !flag1;
        end
    endgenerate

    assign fork_accept = fork_valid & fork_ready;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            flag0     <= 1'b0;
            flag1     <= 1'b0;
            fork_word <= '0;
        end else if (fork_accept) begin
            flag0     <= 1'b1;
            flag1     <= 1'b1;
            fork_word <= fork_data;
        end else begin
            flag0 <= flag0 & !iReady_BM0;
            flag1 <= flag1 & !iReady_BM1;
        end
    end

    assign oValid_BM0 = flag0;
    assign oValid_BM1 = flag1;
    assign oData_BM0  = fork_word[WIDTH0-1:0];
    assign oData_BM1  = fork_word[WW-1:WIDTH0];

endmodule

// File: tb/tb_stream_join_pipe_fork.sv
// Bench for stream_join_pipe_fork: a BURST="yes" and a BURST="no" instance side by side,
// table-driven vectors, directed streaming/stall sequences and a random scoreboard run.
module tb_stream_join_pipe_fork;

    localparam int W0 = 8;
    localparam int W1 = 4;
`ifdef STREAM_JOIN_PIPE_FORK_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_v0[2], in_v1[2], in_r0[2], in_r1[2];
    logic [W0-1:0] in_d0[2];
    logic [W1-1:0] in_d1[2];

    logic          y_rdy0, y_rdy1, y_ov0, y_ov1;
    logic [W0-1:0] y_od0;
    logic [W1-1:0] y_od1;
    logic          n_rdy0, n_rdy1, n_ov0, n_ov1;
    logic [W0-1:0] n_od0;
    logic [W1-1:0] n_od1;

    stream_join_pipe_fork #(.WIDTH0(W0), .WIDTH1(W1), .BURST("yes")) dut_yes (
        .iCLK(clk), .iRST(rst),
        .iValid_AS0(in_v0[0]), .oReady_AS0(y_rdy0), .iData_AS0(in_d0[0]),
        .iValid_AS1(in_v1[0]), .oReady_AS1(y_rdy1), .iData_AS1(in_d1[0]),
        .oValid_BM0(y_ov0), .iReady_BM0(in_r0[0]), .oData_BM0(y_od0),
        .oValid_BM1(y_ov1), .iReady_BM1(in_r1[0]), .oData_BM1(y_od1)
    );

    stream_join_pipe_fork #(.WIDTH0(W0), .WIDTH1(W1), .BURST("no")) dut_no (
        .iCLK(clk), .iRST(rst),
        .iValid_AS0(in_v0[1]), .oReady_AS0(n_rdy0), .iData_AS0(in_d0[1]),
        .iValid_AS1(in_v1[1]), .oReady_AS1(n_rdy1), .iData_AS1(in_d1[1]),
        .oValid_BM0(n_ov0), .iReady_BM0(in_r0[1]), .oData_BM0(n_od0),
        .oValid_BM1(n_ov1), .iReady_BM1(in_r1[1]), .oData_BM1(n_od1)
    );

    typedef struct {
        logic          rdy0, rdy1, ov0, ov1;
        logic [W0-1:0] od0;
        logic [W1-1:0] od1;
    } obs_t;

    typedef struct {
        logic          rst, v0, v1, r;
        logic [W0-1:0] d0;
        logic [W1-1:0] d1;
        logic          e_rdy0, e_rdy1, e_ov, e_dchk;
        logic [W0-1:0] e_od0;
        logic [W1-1:0] e_od1;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    vec_t tbl[$];
    obs_t last_obs[2];

    // ---------------- scoreboard state ----------------
    logic [W0-1:0] sy0_q[$], sn0_q[$], ey0_q[$], en0_q[$];
    logic [W1-1:0] sy1_q[$], sn1_q[$], ey1_q[$], en1_q[$];
    int            t0_y[$], t0_n[$];
    logic          pres0[2], pres1[2], busy0[2], busy1[2], held0[2], held1[2];
    logic [W0-1:0] held_d0[2];
    logic [W1-1:0] held_d1[2];
    logic          rdy_set0[2], rdy_set1[2];
    logic          rand_rdy, rand_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t observe(input int d);
        obs_t o;
        if (d == 0) begin
            o.rdy0 = y_rdy0; o.rdy1 = y_rdy1; o.ov0 = y_ov0; o.ov1 = y_ov1;
            o.od0 = y_od0; o.od1 = y_od1;
        end else begin
            o.rdy0 = n_rdy0; o.rdy1 = n_rdy1; o.ov0 = n_ov0; o.ov1 = n_ov1;
            o.od0 = n_od0; o.od1 = n_od1;
        end
        return o;
    endfunction

    function automatic int s_size(input int d, input int k);
        case ({d[0], k[0]})
            2'b00:   return sy0_q.size();
            2'b01:   return sy1_q.size();
            2'b10:   return sn0_q.size();
            default: return sn1_q.size();
        endcase
    endfunction

    function automatic logic [7:0] s_front(input int d, input int k);
        case ({d[0], k[0]})
            2'b00:   return sy0_q[0];
            2'b01:   return 8'(sy1_q[0]);
            2'b10:   return sn0_q[0];
            default: return 8'(sn1_q[0]);
        endcase
    endfunction

    task automatic s_push(input int d, input int k, input logic [7:0] v);
        case ({d[0], k[0]})
            2'b00:   sy0_q.push_back(v);
            2'b01:   sy1_q.push_back(v[W1-1:0]);
            2'b10:   sn0_q.push_back(v);
            default: sn1_q.push_back(v[W1-1:0]);
        endcase
    endtask

    task automatic s_pop(input int d, input int k);
        case ({d[0], k[0]})
            2'b00:   void'(sy0_q.pop_front());
            2'b01:   void'(sy1_q.pop_front());
            2'b10:   void'(sn0_q.pop_front());
            default: void'(sn1_q.pop_front());
        endcase
    endtask

    function automatic int e_size(input int d, input int k);
        case ({d[0], k[0]})
            2'b00:   return ey0_q.size();
            2'b01:   return ey1_q.size();
            2'b10:   return en0_q.size();
            default: return en1_q.size();
        endcase
    endfunction

    function automatic logic [7:0] e_front(input int d, input int k);
        case ({d[0], k[0]})
            2'b00:   return ey0_q[0];
            2'b01:   return 8'(ey1_q[0]);
            2'b10:   return en0_q[0];
            default: return 8'(en1_q[0]);
        endcase
    endfunction

    task automatic e_push(input int d, input int k, input logic [7:0] v);
        case ({d[0], k[0]})
            2'b00:   ey0_q.push_back(v);
            2'b01:   ey1_q.push_back(v[W1-1:0]);
            2'b10:   en0_q.push_back(v);
            default: en1_q.push_back(v[W1-1:0]);
        endcase
    endtask

    task automatic e_pop(input int d, input int k);
        case ({d[0], k[0]})
            2'b00:   void'(ey0_q.pop_front());
            2'b01:   void'(ey1_q.pop_front());
            2'b10:   void'(en0_q.pop_front());
            default: void'(en1_q.pop_front());
        endcase
    endtask

    function automatic int pending();
        int n = 0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++)
                n += s_size(d, k) + e_size(d, k);
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_v0[d] = 1'b0; in_v1[d] = 1'b0; in_r0[d] = 1'b1; in_r1[d] = 1'b1;
            in_d0[d] = '0;   in_d1[d] = '0;
            pres0[d] = 1'b0; pres1[d] = 1'b0; busy0[d] = 1'b0; busy1[d] = 1'b0;
            held0[d] = 1'b0; held1[d] = 1'b0; rdy_set0[d] = 1'b1; rdy_set1[d] = 1'b1;
        end
        sy0_q.delete(); sn0_q.delete(); ey0_q.delete(); en0_q.delete();
        sy1_q.delete(); sn1_q.delete(); ey1_q.delete(); en1_q.delete();
        t0_y.delete();  t0_n.delete();
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_pairs(input int n, input bit rnd);
        for (int i = 0; i < n; i++)
            for (int d = 0; d < 2; d++) begin
                s_push(d, 0, rnd ? 8'($urandom) : 8'(i));
                s_push(d, 1, rnd ? 8'($urandom) : 8'(i));
            end
    endtask

    // One clock of the scoreboard run: drive at negedge, observe 1 ns later.
    task automatic step();
        obs_t o;
        logic x0, x1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!busy0[d]) pres0[d] = (s_size(d, 0) != 0) && (!rand_gap || $urandom_range(0, 3) != 0);
            if (!busy1[d]) pres1[d] = (s_size(d, 1) != 0) && (!rand_gap || $urandom_range(0, 3) != 0);
            in_v0[d] = pres0[d];
            in_v1[d] = pres1[d];
            in_d0[d] = pres0[d] ? s_front(d, 0) : 8'($urandom);
            in_d1[d] = pres1[d] ? W1'(s_front(d, 1)) : W1'($urandom);
            in_r0[d] = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_set0[d];
            in_r1[d] = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_set1[d];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            o = observe(d);
            last_obs[d] = o;
            if (held0[d]) begin
                check("bm0_hold_valid", 32'(o.ov0), 32'd1);
                check("bm0_hold_data", 32'(o.od0), 32'(held_d0[d]));
            end
            if (held1[d]) begin
                check("bm1_hold_valid", 32'(o.ov1), 32'd1);
                check("bm1_hold_data", 32'(o.od1), 32'(held_d1[d]));
            end
            held0[d] = o.ov0 && !in_r0[d]; held_d0[d] = o.od0;
            held1[d] = o.ov1 && !in_r1[d]; held_d1[d] = o.od1;
            if (o.ov0 && in_r0[d]) begin
                if (d == 0) t0_y.push_back(cyc); else t0_n.push_back(cyc);
                if (e_size(d, 0) == 0) check("bm0_spurious", 32'(o.ov0), 32'd0);
                else begin
                    check("bm0_data", 32'(o.od0), 32'(e_front(d, 0)));
                    e_pop(d, 0);
                end
            end
            if (o.ov1 && in_r1[d]) begin
                if (e_size(d, 1) == 0) check("bm1_spurious", 32'(o.ov1), 32'd0);
                else begin
                    check("bm1_data", 32'(o.od1), 32'(e_front(d, 1)));
                    e_pop(d, 1);
                end
            end
            x0 = in_v0[d] & o.rdy0;
            x1 = in_v1[d] & o.rdy1;
            if (x0 || x1) begin
                check("join_pair", 32'(x0), 32'(x1));
                if (x0 && x1) begin
                    e_push(d, 0, 8'(in_d0[d]));
                    e_push(d, 1, 8'(in_d1[d]));
                    s_pop(d, 0);
                    s_pop(d, 1);
                end
            end
            busy0[d] = pres0[d] && !x0;
            busy1[d] = pres1[d] && !x1;
        end
        cyc++;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(pending()), 32'd0);
    endtask

    task automatic add_row(input logic rst_, input logic v0, input logic v1, input logic r,
                           input logic [7:0] d0, input logic [3:0] d1,
                           input logic e_rdy0, input logic e_rdy1, input logic e_ov,
                           input logic e_dchk, input logic [7:0] e_od0, input logic [3:0] e_od1);
        vec_t t;
        t.rst = rst_; t.v0 = v0; t.v1 = v1; t.r = r; t.d0 = d0; t.d1 = d1;
        t.e_rdy0 = e_rdy0; t.e_rdy1 = e_rdy1; t.e_ov = e_ov; t.e_dchk = e_dchk;
        t.e_od0 = e_od0; t.e_od1 = e_od1;
        tbl.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        obs_t o;
        do_reset();

        // ---- table: reset state, join wait, single word, reset while valid ----
        add_row(0, 0, 0, 1, 8'h00, 4'h0, 0, 0, 0, 1, 8'h00, 4'h0);
        repeat (3) add_row(0, 1, 0, 1, 8'h5A, 4'h0, 0, 1, 0, 0, 8'h00, 4'h0);
        add_row(0, 1, 1, 1, 8'h5A, 4'h3, 1, 1, 0, 0, 8'h00, 4'h0);
        repeat (LAT - 1) add_row(0, 0, 0, 1, 8'h11, 4'h1, 0, 0, 0, 0, 8'h00, 4'h0);
        add_row(0, 0, 0, 1, 8'h22, 4'h2, 0, 0, 1, 1, 8'h5A, 4'h3);
        add_row(0, 0, 0, 1, 8'h33, 4'h3, 0, 0, 0, 0, 8'h00, 4'h0);
        add_row(0, 1, 1, 0, 8'hC3, 4'h9, 1, 1, 0, 0, 8'h00, 4'h0);
        repeat (LAT - 1) add_row(0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0);
        add_row(0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 1, 1, 8'hC3, 4'h9);
        add_row(1, 0, 0, 0, 8'h00, 4'h0, 0, 0, 1, 1, 8'hC3, 4'h9);
        add_row(0, 0, 1, 1, 8'h00, 4'h0, 1, 0, 0, 1, 8'h00, 4'h0);
        add_row(0, 0, 0, 1, 8'h00, 4'h0, 0, 0, 0, 1, 8'h00, 4'h0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst;
            for (int d = 0; d < 2; d++) begin
                in_v0[d] = tbl[i].v0; in_v1[d] = tbl[i].v1;
                in_d0[d] = tbl[i].d0; in_d1[d] = tbl[i].d1;
                in_r0[d] = tbl[i].r;  in_r1[d] = tbl[i].r;
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                o = observe(d);
                check($sformatf("row%0d_dut%0d_rdy0", i, d), 32'(o.rdy0), 32'(tbl[i].e_rdy0));
                check($sformatf("row%0d_dut%0d_rdy1", i, d), 32'(o.rdy1), 32'(tbl[i].e_rdy1));
                check($sformatf("row%0d_dut%0d_ov0", i, d), 32'(o.ov0), 32'(tbl[i].e_ov));
                check($sformatf("row%0d_dut%0d_ov1", i, d), 32'(o.ov1), 32'(tbl[i].e_ov));
                if (tbl[i].e_dchk) begin
                    check($sformatf("row%0d_dut%0d_od0", i, d), 32'(o.od0), 32'(tbl[i].e_od0));
                    check($sformatf("row%0d_dut%0d_od1", i, d), 32'(o.od1), 32'(tbl[i].e_od1));
                end
            end
        end

        // ---- streaming 8 pairs, all readies high ----
        do_reset();
        load_pairs(8, 1'b0);
        base = cyc;
        drain("stream_drain", 100);
        check("stream_yes_count", 32'(t0_y.size()), 32'd8);
        check("stream_no_count", 32'(t0_n.size()), 32'd8);
        foreach (t0_y[i]) check($sformatf("stream_yes_t%0d", i), 32'(t0_y[i]), 32'(base + LAT + i));
        foreach (t0_n[i]) check($sformatf("stream_no_t%0d", i), 32'(t0_n[i]), 32'(base + LAT + 2 * i));

        // ---- split stall: BM1 held off for 4 cycles once the first word shows ----
        do_reset();
        load_pairs(6, 1'b1);
        repeat (LAT) step();
        for (int k = 0; k < 4; k++) begin
            rdy_set1[0] = 1'b0;
            rdy_set1[1] = 1'b0;
            step();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("stall%0d_dut%0d_ov0", k, d), 32'(last_obs[d].ov0), (k == 0) ? 32'd1 : 32'd0);
                check($sformatf("stall%0d_dut%0d_ov1", k, d), 32'(last_obs[d].ov1), 32'd1);
                check($sformatf("stall%0d_dut%0d_rdy0", k, d), 32'(last_obs[d].rdy0), 32'd0);
            end
        end
        rdy_set1[0] = 1'b1;
        rdy_set1[1] = 1'b1;
        drain("stall_drain", 200);

        // ---- random valids and readies ----
        do_reset();
        load_pairs(60, 1'b1);
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        drain("random_drain", 3000);

        // ---- reset in the middle of traffic: old words must never reappear ----
        do_reset();
        load_pairs(20, 1'b1);
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        repeat (12) step();
        do_reset();
        load_pairs(10, 1'b1);
        rand_rdy = 1'b1;
        drain("midreset_drain", 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_join_pipe_fork.md
STREAM_JOIN_PIPE_FORK -- requirements
Module: stream_join_pipe_fork

Interface
REQ-001 Parameter WIDTH0, default 8: width of stream 0 data in and out.
REQ-002 Parameter WIDTH1, default 8: width of stream 1 data in and out.
REQ-003 Parameter BURST, default "yes": "yes" gives full-throughput fork; "no" gives a one-bubble fork.
REQ-004 iCLK  in  1  clock; all state updates on rising edge.
REQ-005 iRST  in  1  reset, synchronous, active-high.
REQ-006 iValid_AS0 in 1 / oReady_AS0 out 1 / iData_AS0 in WIDTH0: input stream 0 handshake and data.
REQ-007 iValid_AS1 in 1 / oReady_AS1 out 1 / iData_AS1 in WIDTH1: input stream 1 handshake and data.
REQ-008 oValid_BM0 out 1 / iReady_BM0 in 1 / oData_BM0 out WIDTH0: output stream 0.
REQ-009 oValid_BM1 out 1 / iReady_BM1 in 1 / oData_BM1 out WIDTH1: output stream 1.

Function
REQ-010 Transfer on any port occurs in a cycle where valid and ready are both 1.
REQ-011 Join stage is combinational: join_valid = iValid_AS0 & iValid_AS1.
REQ-012 Join handshake: oReady_AS0 = join_ready & iValid_AS1; oReady_AS1 = join_ready & iValid_AS0.
- Both inputs are always consumed in the same cycle, never one alone.
REQ-013 Joined word = {iData_AS1, iData_AS0}, stream 0 in the LSBs.
REQ-014 Pipe stage (when compiled in) is a single valid/data register:
- upstream ready = !pipe_valid | down_ready.
- data loads on upstream transfer.
- pipe_valid set on upstream transfer, cleared on downstream transfer without a refill.
REQ-015 Fork stage registers the word and holds one pending flag per output.
- On accept, both flags set.
- oValid_BMk = flag k; each flag clears independently on its output's transfer.
REQ-016 Fork data: oData_BM0 = word[WIDTH0-1:0]; oData_BM1 = word[WIDTH0+WIDTH1-1:WIDTH0].
- Output data is stable while its flag is set.
REQ-017 Fork ready, BURST="yes": each flag is either 0 or being transferred this cycle.
- Gives one word per cycle when both outputs are ready.
REQ-018 Fork ready, BURST="no": both flags 0.
- Max throughput one word per 2 cycles.
REQ-019 Latency, pipe compiled in: join transfer at edge N gives oValid_BM0/1 high after edge N+1.
- Latency 2 cycles, no stalls.
REQ-020 An output that stalls holds only its own flag; the other output may complete earlier.
- The next word is not accepted until both flags are cleared as per REQ-017/018.
REQ-021 Backpressure propagates combinationally through the join.
- No input data is lost or duplicated under any ready pattern.
REQ-022 No combinational path from iValid_AS* to oValid_BM*.

Reset
REQ-023 While iRST=1 at an edge:
- pipe_valid and both fork flags are cleared to 0.
- Data registers are cleared to 0.
REQ-024 After reset: oValid_BM0=0, oValid_BM1=0, oData_BM0=0, oData_BM1=0.
- oReady_AS0 = iValid_AS1 and oReady_AS1 = iValid_AS0.
REQ-025 Reset asserted mid-transfer discards all in-flight words.
- A pending output word is dropped and never re-presented.

Configuration
REQ-026 Macro STREAM_JOIN_PIPE_FORK_PIPE_EN, when defined, includes the REQ-014 pipe stage between join and fork; latency 2.
REQ-027 When STREAM_JOIN_PIPE_FORK_PIPE_EN is undefined, the join connects directly to the fork.
- join_ready = fork ready; latency 1; all other behaviour identical.

Verification (WIDTH0=8, WIDTH1=4, pipe enabled)
REQ-028 Join wait: iValid_AS0=1 with iData_AS0=0x5A, iValid_AS1=0 for 3 cycles.
- oReady_AS0=0 and no output.
- Then iValid_AS1=1 with iData_AS1=0x3: one transfer, oData_BM0=0x5A and oData_BM1=0x3 two cycles later.
REQ-029 Streaming, BURST="yes", all readies 1, 8 input pairs (0x00..0x07, 0x0..0x7): 8 consecutive output cycles in order, no bubbles.
REQ-030 Same stimulus with BURST="no": outputs appear on alternate cycles; data order preserved.
REQ-031 Split stall: iReady_BM1=0 for 4 cycles, iReady_BM0=1.
- BM0 transfers once and drops valid.
- BM1 holds its data stable.
- Inputs stall until iReady_BM1=1, then resume.
REQ-032 Reset: assert iRST for 1 cycle while both outputs are valid -> next cycle both oValid=0, data=0.
REQ-033 Macro undefined: single pair produces outputs 1 cycle after the join transfer.
